// File: rtl/fluxo_dados_memoria.sv
// fluxo_dados_memoria
// Datapath of the memory game. It executes the control unit's commands and
// returns status flags.
//
// Contents:
//   - 4-bit address counter
//   - fixed 16-word sequence ROM
//   - play register
//   - comparator
//   - two-stage button synchronizer with a rising-edge (press) detector
//
// Ports:
//   clock, reset   rising-edge clock, synchronous active-high reset
//   botoes[N]      raw asynchronous buttons, active-high
//   zeraC, contaC  counter clear (dominant) / increment
//   zeraR, registraR  play register clear (dominant) / load from synced buttons
//   fim            counter == LIMITE
//   igual          ROM word at current address == play register
//   jogada         one-cycle pulse per button press
//   db_*           debug views of counter, ROM word, register, |buttons
//
// Command semantics:
//   There is no handshake. Each command is a level.
//   It acts on every rising edge where it is high.
//   A clear command always wins over its companion command.
module fluxo_dados_memoria #(
  parameter int N      = 4,
  parameter int LIMITE = 15
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [N-1:0] botoes,
  input  logic         zeraC,
  input  logic         contaC,
  input  logic         zeraR,
  input  logic         registraR,
  output logic         fim,
  output logic         igual,
  output logic         jogada,
  output logic [3:0]   db_contagem,
  output logic [N-1:0] db_memoria,
  output logic [N-1:0] db_jogada,
  output logic         db_tem_jogada
);

  logic [3:0]   contagem;
  logic [N-1:0] registro;
  logic [N-1:0] sync1;
  logic [N-1:0] sync2;
  logic         prev;
  logic         tem_jogada;
  logic [N-1:0] rom_word;

  // Address counter: clear dominates increment, natural 4-bit wrap 15 -> 0.
  always_ff @(posedge clock) begin
    if (reset) begin
      contagem <= 4'd0;
    end else if (zeraC) begin
      contagem <= 4'd0;
    end else if (contaC) begin
      contagem <= contagem + 4'd1;
    end
  end

  // Play register loads the synchronized buttons, never the raw pins.
  // A button released before the load edge is therefore recorded as 0.
  always_ff @(posedge clock) begin
    if (reset) begin
      registro <= '0;
    end else if (zeraR) begin
      registro <= '0;
    end else if (registraR) begin
      registro <= sync2;
    end
  end

  // Two-flop synchronizer plus the history bit for press detection.
  // Reset clears all of them.
  // A button still held after reset therefore yields a fresh press pulse.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
      prev  <= 1'b0;
    end else begin
      sync1 <= botoes;
      sync2 <= sync1;
      prev  <= tem_jogada;
    end
  end

  assign tem_jogada = |sync2;

  // Pulses only on the transition from "no button" to "any button".
  // Adding a second button while one is held gives no new pulse.
  assign jogada = tem_jogada & ~prev;

  // Fixed sequence ROM, combinational read at the counter address.
  always_comb begin
    rom_word = '0;
    case (contagem)
      4'd0:    rom_word = N'(4'b0001);
      4'd1:    rom_word = N'(4'b0010);
      4'd2:    rom_word = N'(4'b0100);
      4'd3:    rom_word = N'(4'b1000);
      4'd4:    rom_word = N'(4'b0100);
      4'd5:    rom_word = N'(4'b0010);
      4'd6:    rom_word = N'(4'b0001);
      4'd7:    rom_word = N'(4'b0001);
      4'd8:    rom_word = N'(4'b0010);
      4'd9:    rom_word = N'(4'b0010);
      4'd10:   rom_word = N'(4'b0100);
      4'd11:   rom_word = N'(4'b0100);
      4'd12:   rom_word = N'(4'b1000);
      4'd13:   rom_word = N'(4'b1000);
      4'd14:   rom_word = N'(4'b0001);
      default: rom_word = N'(4'b0100);
    endcase
  end

  assign fim           = (contagem == 4'(LIMITE));
  assign igual         = (rom_word == registro);
  assign db_contagem   = contagem;
  assign db_memoria    = rom_word;
  assign db_jogada     = registro;
  assign db_tem_jogada = tem_jogada;

endmodule

// File: tb/tb_fluxo_dados_memoria.sv
module tb_fluxo_dados_memoria;

  localparam int N = 4;

  // ---------------- clock / reset / DUT ----------------
  logic         clock;
  logic         reset;
  logic [N-1:0] botoes;
  logic         zeraC, contaC, zeraR, registraR;
  logic         fim, igual, jogada, db_tem_jogada;
  logic [3:0]   db_contagem;
  logic [N-1:0] db_memoria, db_jogada;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  fluxo_dados_memoria #(.N(N), .LIMITE(15)) dut (
    .clock(clock), .reset(reset), .botoes(botoes),
    .zeraC(zeraC), .contaC(contaC), .zeraR(zeraR), .registraR(registraR),
    .fim(fim), .igual(igual), .jogada(jogada),
    .db_contagem(db_contagem), .db_memoria(db_memoria),
    .db_jogada(db_jogada), .db_tem_jogada(db_tem_jogada)
  );

  // ---------------- reference model ----------------
  // The game sequence, written straight from the table.
  logic [3:0] rom [16] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                           4'b0100, 4'b0010, 4'b0001, 4'b0001,
                           4'b0010, 4'b0010, 4'b0100, 4'b0100,
                           4'b1000, 4'b1000, 4'b0001, 4'b0100};

  int         m_cnt;
  logic [3:0] m_reg;
  // Button values seen at the last three edges, newest at the back.
  // Index [$-1] is the value currently visible after synchronization.
  // Index [$-2] tells whether a button was already down one cycle earlier.
  logic [3:0] hist[$];

  int compared   = 0;
  int mismatched = 0;

  function automatic logic [3:0] m_sync();
    return hist[hist.size()-2];
  endfunction

  function automatic logic m_jogada();
    return (|hist[hist.size()-2]) && !(|hist[hist.size()-3]);
  endfunction

  task automatic model_edge();
    if (reset) begin
      m_cnt = 0;
      m_reg = 4'b0;
      hist.delete();
      hist.push_back(4'b0);
      hist.push_back(4'b0);
      hist.push_back(4'b0);
    end else begin
      if (zeraR)          m_reg = 4'b0;
      else if (registraR) m_reg = m_sync();
      if (zeraC)          m_cnt = 0;
      else if (contaC)    m_cnt = (m_cnt + 1) % 16;
      hist.push_back(botoes);
      if (hist.size() > 3) void'(hist.pop_front());
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("db_contagem",   8'(db_contagem),   8'(m_cnt));
    chk("db_memoria",    8'(db_memoria),    8'(rom[m_cnt]));
    chk("db_jogada",     8'(db_jogada),     8'(m_reg));
    chk("fim",           8'(fim),           8'(m_cnt == 15));
    chk("igual",         8'(igual),         8'(rom[m_cnt] == m_reg));
    chk("jogada",        8'(jogada),        8'(m_jogada()));
    chk("db_tem_jogada", 8'(db_tem_jogada), 8'(|m_sync()));
  endtask

  // ---------------- driver ----------------
  // One clock edge: advance the model with the inputs the DUT samples.
  // Then check every output 1 ns after the edge.
  task automatic tick();
    model_edge();
    @(posedge clock);
    #1;
    check_all();
  endtask

  task automatic cmd(input logic zc, input logic cc, input logic zr, input logic rr);
    zeraC = zc; contaC = cc; zeraR = zr; registraR = rr;
  endtask

  int pulses, first_pulse;

  initial begin
    reset = 1'b1; botoes = '0; cmd(0, 0, 0, 0);

    // Reset, then idle.
    tick(); tick();
    chk("rst_contagem", 8'(db_contagem), 8'd0);
    chk("rst_memoria",  8'(db_memoria),  8'h1);
    chk("rst_fim",      8'(fim),         8'd0);
    chk("rst_igual",    8'(igual),       8'd0);
    chk("rst_jogada",   8'(jogada),      8'd0);
    reset = 1'b0;
    repeat (3) tick();

    // Hold 0001 for 10 cycles: exactly one pulse, after the 2nd edge.
    botoes = 4'b0001; pulses = 0; first_pulse = -1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (jogada) begin
        pulses++;
        if (first_pulse < 0) first_pulse = i;
      end
    end
    chk("hold_pulses",  8'(pulses),      8'd1);
    chk("hold_latency", 8'(first_pulse), 8'd2);

    // Release, then press 0010: a second single pulse.
    botoes = 4'b0; repeat (3) tick();
    botoes = 4'b0010; pulses = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (jogada) pulses++;
    end
    chk("press2_pulses", 8'(pulses), 8'd1);

    // Adding a second button while one is held produces no pulse.
    botoes = 4'b0110; pulses = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (jogada) pulses++;
    end
    chk("add_button_pulses", 8'(pulses), 8'd0);
    botoes = 4'b0; repeat (3) tick();

    // Clear the register, press 0001, load while held: match at address 0.
    cmd(0, 0, 1, 0); tick(); cmd(0, 0, 0, 0);
    botoes = 4'b0001; tick(); tick();
    cmd(0, 0, 0, 1); tick(); cmd(0, 0, 0, 0);
    chk("load_jogada", 8'(db_jogada), 8'h1);
    chk("load_igual",  8'(igual),     8'd1);
    cmd(0, 1, 0, 0); tick(); cmd(0, 0, 0, 0);
    chk("addr1_memoria", 8'(db_memoria), 8'h2);
    chk("addr1_igual",   8'(igual),      8'd0);
    botoes = 4'b0; repeat (2) tick();

    // Count to 15: fim asserts. Wrap to 0: fim drops.
    cmd(1, 0, 0, 0); tick();
    cmd(0, 1, 0, 0); repeat (15) tick();
    cmd(0, 0, 0, 0); tick();
    chk("lim_fim",     8'(fim),         8'd1);
    chk("lim_memoria", 8'(db_memoria),  8'h4);
    cmd(0, 1, 0, 0); tick(); cmd(0, 0, 0, 0);
    chk("wrap_count",  8'(db_contagem), 8'd0);
    chk("wrap_fim",    8'(fim),         8'd0);

    // Go to count 5, then raise zeraC and contaC together: the clear wins.
    cmd(0, 1, 0, 0); repeat (5) tick();
    cmd(1, 1, 0, 0); tick(); cmd(0, 0, 0, 0);
    chk("zc_prio", 8'(db_contagem), 8'd0);

    // A multi-button register never matches, at any address.
    botoes = 4'b0011; tick(); tick();
    cmd(0, 0, 0, 1); tick(); cmd(0, 0, 0, 0);
    chk("multi_reg", 8'(db_jogada), 8'h3);
    for (int a = 0; a < 16; a++) begin
      cmd(0, 1, 0, 0); tick();
    end
    cmd(0, 0, 1, 1); tick(); cmd(0, 0, 0, 0);
    chk("zr_prio", 8'(db_jogada), 8'h0);
    botoes = 4'b0; repeat (3) tick();

    // Reset while 1000 is held at count 7.
    // Expect a fresh pulse 2 edges after release.
    cmd(1, 0, 0, 0); tick();
    cmd(0, 1, 0, 0); repeat (7) tick(); cmd(0, 0, 0, 0);
    botoes = 4'b1000; repeat (2) tick();
    cmd(0, 0, 0, 1); tick(); cmd(0, 0, 0, 0);
    chk("pre_rst_count", 8'(db_contagem), 8'd7);
    repeat (3) tick();
    reset = 1'b1; tick(); reset = 1'b0;
    chk("mid_rst_count", 8'(db_contagem), 8'd0);
    chk("mid_rst_reg",   8'(db_jogada),   8'd0);
    tick();
    chk("post_rst_jog1", 8'(jogada), 8'd0);
    tick();
    chk("post_rst_jog2", 8'(jogada), 8'd1);
    tick();
    chk("post_rst_jog3", 8'(jogada), 8'd0);

    // Randomized commands and buttons against the model.
    for (int i = 0; i < 400; i++) begin
      zeraC     = ($urandom_range(0, 15) == 0);
      contaC    = ($urandom_range(0, 1) == 1);
      zeraR     = ($urandom_range(0, 7) == 0);
      registraR = ($urandom_range(0, 2) == 0);
      reset     = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 5))
          0, 1:    botoes = 4'b0;
          2:       botoes = 4'(1 << $urandom_range(0, 3));
          3:       botoes = 4'($urandom_range(0, 15));
          default: botoes = rom[m_cnt];
        endcase
      end
      tick();
    end
    reset = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/fluxo_dados_memoria.md
Name: fluxo_dados_memoria

Overview:
- Datapath that answers the game control unit's commands: zeraC, contaC, zeraR, registraR.
- Returns status fim, igual and jogada to that control unit.
- Holds the address counter, the fixed sequence ROM, the play register, the comparator and the button synchronizer / edge detector.
- Sits between the board buttons and the control unit inside the game top level.

Parameters:
- N, 4, width of button vector, ROM word and play register (one-hot button code).
- LIMITE, 15, counter value at which fim asserts (last sequence position).

Ports:
- clock  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- botoes  in  N  raw asynchronous button inputs, active-high
- zeraC  in  1  synchronous clear of address counter
- contaC  in  1  increment address counter
- zeraR  in  1  synchronous clear of play register
- registraR  in  1  load play register from synchronized buttons
- fim  out  1  counter == LIMITE (combinational from counter)
- igual  out  1  ROM word at current address == play register (combinational)
- jogada  out  1  one-cycle pulse on button press
- db_contagem  out  4  counter value
- db_memoria  out  N  ROM word at current address
- db_jogada  out  N  play register value
- db_tem_jogada  out  1  OR of synchronized buttons

Behaviour:
- Reset (sampled high on a clock edge):
  - counter=0, play register=0, both synchronizer stages=0, edge-detect history=0.
  - Consequently fim=0 (LIMITE≠0), jogada=0, db_tem_jogada=0, db_jogada=0, db_contagem=0, db_memoria=ROM[0], igual=0 (ROM[0]≠0).
  - Reset overrides every other input.
- Counter (4 bits):
  - zeraC=1 → 0 next edge, with priority over contaC.
  - Otherwise contaC=1 → +1, wrapping 15→0.
  - Otherwise hold.
- Play register (N bits):
  - zeraR=1 → 0, with priority over registraR.
  - Otherwise registraR=1 → load sync2.
  - Otherwise hold.
  - It loads sync2, the second-stage synchronized buttons, never raw botoes. If the buttons are released before the load edge, the register loads 0.
- Synchronizer: sync1<=botoes; sync2<=sync1 on every edge. db_tem_jogada=|sync2.
- Edge detector:
  - prev<=|sync2 each edge; jogada = (|sync2) & ~prev.
  - Pulse is exactly 1 cycle per press regardless of hold length.
  - A new pulse requires all buttons released (|sync2=0 for ≥1 cycle) and pressed again.
  - Latency: botoes stable nonzero before edge k → jogada high during the cycle after edge k+1.
  - A second button added while one is already held produces no pulse.
- ROM:
  - 16×N, combinational read at the counter address; contents fixed, not parameterized.
  - Addresses 0..15: 0001,0010,0100,1000,0100,0010,0001,0001,0010,0010,0100,0100,1000,1000,0001,0100.
- Comparator: igual=1 iff ROM word equals play register bit-for-bit (multi-button or zero register never matches).
- fim: combinational, fim=(counter==LIMITE). It holds while the counter stays there and drops on wrap or clear.
- Simultaneous zeraC&contaC or zeraR&registraR: the clear wins, no error flagged.
- Reset mid-press:
  - Synchronizer cleared; if the buttons are still held after reset, a fresh jogada pulse is produced 2 edges later.
  - This is intended behaviour, not suppressed.
- No state beyond the counter, register, synchronizer and edge history. Outputs other than jogada are purely functions of that state.

Test Plan:
- Reset then idle → db_contagem=0, db_memoria=0001, fim=0, igual=0, jogada=0.
- Hold botoes=0001 for 10 cycles → exactly one jogada pulse, starting the cycle after the 2nd edge; release, press 0010 → second single pulse.
- zeraR, then press 0001 and registraR during hold → db_jogada=0001, igual=1 at address 0. Then contaC once → address 1, db_memoria=0010, igual=0.
- contaC 15 times from 0 → fim=1 at count 15, db_memoria=0100. One more contaC → count 0, fim=0. zeraC&contaC together at count 5 → count 0.
- registraR with botoes=0011 → db_jogada=0011, igual=0 at every address. registraR&zeraR together → register 0.
- Assert reset while 1000 is held and count=7 → count 0, register 0, jogada pulse again 2 edges after reset deasserts with the button still held.
